pwm_count_stage: RTL and testbench
==================================

# pwm_count_stage

Registered PWM stage sitting directly downstream of the modulo-N counter. It consumes the counter's count value, compares it with a duty setting to produce a PWM waveform, and emits a per-period strobe. Duty updates arrive through a valid/ready handshake and are double-buffered so they take effect only at a period boundary (count == 0). It also checks that the incoming count sequence is a legal modulo-N progression and raises a sticky error flag otherwise.

## Interface
- N, 4, modulus of the upstream counter (count runs 0..N-1); N >= 2
- W, 2, width of count input; 2^W >= N
- clk  input  1  rising-edge clock shared with the upstream counter
- rst  input  1  asynchronous, active-high reset
- cnt_in  input  W  count value from the upstream modulo-N counter
- duty_in  input  W+1  requested high time in counts (0..N; values > N saturate to N)
- duty_valid  input  1  duty_in is valid
- duty_ready  output  1  stage can accept a duty value (= no update pending)
- pwm_out  output  1  registered PWM output
- period_done  output  1  one-cycle pulse, one cycle after cnt_in == N-1 is sampled
- seq_err  output  1  sticky count-sequence error
- err_clr  input  1  clears seq_err

## Operation
- State: act_duty (W+1), pend_duty (W+1), pend_flag, prev_cnt (W), prev_vld, pwm_out, period_done, seq_err.
- Reset (async, rst=1): all registers 0; pwm_out=0, period_done=0, seq_err=0; duty_ready=1 (combinational ~pend_flag). Handshake inputs are ignored while rst=1.
- Accept: duty_valid & duty_ready at a clock edge -> pend_duty <= min(duty_in, N), pend_flag <= 1. duty_valid is held until accepted; no back-to-back accepts while an update is pending.
- Commit: at an edge where cnt_in == 0 and pend_flag == 1 (pre-edge value) -> act_duty <= pend_duty, pend_flag <= 0. A duty accepted at the same edge as a cnt_in == 0 sample is not committed until the next cnt_in == 0.
- Effective duty: eff = (cnt_in == 0 && pend_flag) ? pend_duty : act_duty, so the new duty governs the boundary cycle itself.
- PWM: pwm_out <= (cnt_in < eff). eff=0 -> constant low; eff=N -> constant high.
- period_done <= (cnt_in == N-1).
- Sequence check (every edge, rst=0): expected = (prev_cnt == N-1) ? 0 : prev_cnt+1. Error when prev_vld && cnt_in != expected && cnt_in != 0, or when cnt_in >= N (even when prev_vld = 0). cnt_in == 0 is always legal (upstream reset/restart). prev_cnt <= cnt_in, prev_vld <= 1.
- seq_err: set on error; cleared by err_clr; set wins if both occur at the same edge.
- Reset mid-operation: pending duty discarded, act_duty returns to 0, pwm_out low from the reset assertion.

## Timing
- Latency cnt_in -> pwm_out / period_done: 1 cycle.
- Latency error-causing sample -> seq_err: 1 cycle.
- duty_ready falls the cycle after acceptance and rises the cycle after commit.
- Worst-case duty update latency: one full period (N cycles) plus 1 cycle.
- No combinational path from cnt_in to any output; duty_ready depends only on registered state.

## Test plan
- N=4, W=2. After reset, duty_in=2 accepted, counter free-running 0,1,2,3,... -> from the first cnt_in=0 after acceptance, pwm_out (1 cycle later) = 1,1,0,0 repeating; duty_ready = 1 again the cycle after that commit.
- duty_in=0, then duty_in=7 -> 0 gives pwm_out constant 0; 7 saturates to 4 and gives constant 1 for full periods; pend_duty reads 4.
- Accept duty=3 at the same edge as cnt_in=0 -> not applied that period; applied at the next cnt_in=0; duty_valid held with duty_ready=0 in between -> no second accept.
- Inject cnt_in sequence 0,1,3 -> seq_err=1 one cycle after the 3 and stays high; err_clr pulse -> seq_err=0. Sequence 2,0 (upstream reset) -> no error. cnt_in=1 as the first sample -> no error. err_clr at the same edge as a new error -> seq_err stays 1.
- period_done: with a free-running count -> exactly one 1-cycle pulse every 4 cycles, one cycle after cnt_in=3.
- Assert rst mid-period with an update pending -> all outputs 0 immediately, duty_ready=1, the pending duty is lost, and pwm_out stays 0 after release until a new duty is committed.

Source files
------------

// File: rtl/pwm_count_stage.sv
// ============================================================================
// Module      : pwm_count_stage
// Description : Registered PWM stage fed by a modulo-N counter. Compares the
//               incoming count with a double-buffered duty value, emits a
//               per-period strobe and flags illegal count progressions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_count_stage #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt_in,
  input  logic [W:0]   duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm_out,
  output logic         period_done,
  output logic         seq_err,
  input  logic         err_clr
);

  localparam logic [W:0]   C_N    = (W+1)'(N);
  localparam logic [W-1:0] C_LAST = W'(N - 1);

  logic [W:0]   r_act_duty;
  logic [W:0]   r_pend_duty;
  logic         r_pend_flag;
  logic [W-1:0] r_prev_cnt;
  logic         r_prev_vld;
  logic         r_pwm;
  logic         r_period_done;
  logic         r_seq_err;

  logic [W:0]   w_duty_sat;
  logic         w_accept;
  logic         w_cnt_zero;
  logic         w_commit;
  logic [W:0]   w_eff;
  logic [W-1:0] w_exp_cnt;
  logic         w_err;

  // Handshake, commit, effective duty and sequence-check decode
  always_comb begin
    w_duty_sat = (duty_in > C_N) ? C_N : duty_in;
    w_accept   = duty_valid & ~r_pend_flag;
    w_cnt_zero = (cnt_in == '0);
    // Commit uses the pre-edge pending flag, so a same-edge accept waits a period
    w_commit   = w_cnt_zero & r_pend_flag;
    // The new duty already governs the boundary cycle in which it commits
    w_eff      = w_commit ? r_pend_duty : r_act_duty;
    w_exp_cnt  = (r_prev_cnt == C_LAST) ? '0 : (r_prev_cnt + W'(1));
    // A zero count is always legal: the upstream counter may have restarted
    w_err      = ({1'b0, cnt_in} >= C_N) |
                 (r_prev_vld & (cnt_in != w_exp_cnt) & ~w_cnt_zero);
  end

  // Duty double buffer: accept into pending, move to active at count zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_duty  <= '0;
      r_pend_duty <= '0;
      r_pend_flag <= 1'b0;
    end else if (w_commit) begin
      r_act_duty  <= r_pend_duty;
      r_pend_flag <= 1'b0;
    end else if (w_accept) begin
      r_pend_duty <= w_duty_sat;
      r_pend_flag <= 1'b1;
    end
  end

  // PWM compare and end-of-period strobe, one cycle behind the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm         <= 1'b0;
      r_period_done <= 1'b0;
    end else begin
      r_pwm         <= ({1'b0, cnt_in} < w_eff);
      r_period_done <= (cnt_in == C_LAST);
    end
  end

  // Count history and sticky sequence error (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_cnt <= '0;
      r_prev_vld <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      r_prev_cnt <= cnt_in;
      r_prev_vld <= 1'b1;
      if (w_err) begin
        r_seq_err <= 1'b1;
      end else if (err_clr) begin
        r_seq_err <= 1'b0;
      end
    end
  end

  assign duty_ready  = ~r_pend_flag;
  assign pwm_out     = r_pwm;
  assign period_done = r_period_done;
  assign seq_err     = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_pwm_count_stage.sv
// ============================================================================
// Module      : tb_pwm_count_stage
// Description : Directed self-checking bench for pwm_count_stage (N=4, W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_count_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cnt_in;
  logic [2:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_done;
  logic       seq_err;
  logic       err_clr;

  int n_vec = 0;
  int n_err = 0;

  pwm_count_stage #(.N(4), .W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm_out    (pwm_out),
    .period_done(period_done),
    .seq_err    (seq_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt_in = 2'd0; duty_in = 3'd0; duty_valid = 1'b0; err_clr = 1'b0;
    tick(); tick();
    n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    n_vec++; if (period_done !== 1'b0) begin n_err++; $display("FAIL reset_pd: got %b want 0", period_done); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", seq_err); end
    n_vec++; if (duty_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", duty_ready); end
    rst = 1'b0;
  endtask

  // Duty 2 accepted mid-period; first sample after reset is 1 (legal)
  task automatic test_duty2();
    logic e;
    cnt_in = 2'd1; duty_in = 3'd2; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    n_vec++; if (duty_ready !== 1'b0) begin n_err++; $display("FAIL d2_ready_low: got %b want 0", duty_ready); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL d2_first1_err: got %b want 0", seq_err); end
    n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL d2_pre_pwm: got %b want 0", pwm_out); end
    for (int c = 2; c < 4; c++) begin
      cnt_in = 2'(c); tick();
      n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL d2_pre_pwm c=%0d: got %b want 0", c, pwm_out); end
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        cnt_in = 2'(c); tick();
        e = (c < 2);
        n_vec++; if (pwm_out !== e) begin n_err++; $display("FAIL d2_pwm p=%0d c=%0d: got %b want %b", p, c, pwm_out, e); end
        e = (c == 3);
        n_vec++; if (period_done !== e) begin n_err++; $display("FAIL d2_pd p=%0d c=%0d: got %b want %b", p, c, period_done, e); end
        if (p == 0 && c == 0) begin
          n_vec++; if (duty_ready !== 1'b1) begin n_err++; $display("FAIL d2_ready_back: got %b want 1", duty_ready); end
        end
      end
    end
  endtask

  // Duty 0 gives constant low, duty 7 saturates to 4 and gives constant high
  task automatic test_saturate();
    logic e;
    cnt_in = 2'd0; tick();
    cnt_in = 2'd1; duty_in = 3'd0; duty_valid = 1'b1; tick();
    duty_valid = 1'b0;
    for (int c = 2; c < 4; c++) begin cnt_in = 2'(c); tick(); end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        cnt_in = 2'(c); tick();
        n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL sat0_pwm p=%0d c=%0d: got %b want 0", p, c, pwm_out); end
      end
    end
    cnt_in = 2'd0; tick();
    cnt_in = 2'd1; duty_in = 3'd7; duty_valid = 1'b1; tick();
    duty_valid = 1'b0;
    n_vec++; if (dut.r_pend_duty !== 3'd4) begin n_err++; $display("FAIL sat7_pend: got %0d want 4", dut.r_pend_duty); end
    for (int c = 2; c < 4; c++) begin cnt_in = 2'(c); tick(); end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        cnt_in = 2'(c); tick();
        e = 1'b1;
        n_vec++; if (pwm_out !== e) begin n_err++; $display("FAIL sat7_pwm p=%0d c=%0d: got %b want 1", p, c, pwm_out); end
      end
    end
  endtask

  // Accept at the same edge as cnt 0: wait a full period; held valid is not re-accepted
  task automatic test_same_edge();
    logic e;
    cnt_in = 2'd0; duty_in = 3'd3; duty_valid = 1'b1; tick();
    duty_in = 3'd1;
    n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL se_c0_pwm: got %b want 1", pwm_out); end
    for (int c = 1; c < 4; c++) begin
      cnt_in = 2'(c); tick();
      n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL se_old_pwm c=%0d: got %b want 1", c, pwm_out); end
      n_vec++; if (duty_ready !== 1'b0) begin n_err++; $display("FAIL se_ready c=%0d: got %b want 0", c, duty_ready); end
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        cnt_in = 2'(c); tick();
        if (p == 0 && c == 0) duty_valid = 1'b0;
        e = (c < 3);
        n_vec++; if (pwm_out !== e) begin n_err++; $display("FAIL se_new_pwm p=%0d c=%0d: got %b want %b", p, c, pwm_out, e); end
      end
    end
  endtask

  task automatic test_seq_err();
    cnt_in = 2'd0; tick();
    cnt_in = 2'd1; tick();
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_01: got %b want 0", seq_err); end
    cnt_in = 2'd3; tick();
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_013: got %b want 1", seq_err); end
    cnt_in = 2'd0; tick();
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_sticky: got %b want 1", seq_err); end
    cnt_in = 2'd1; err_clr = 1'b1; tick();
    err_clr = 1'b0;
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_clr: got %b want 0", seq_err); end
    cnt_in = 2'd2; tick();
    cnt_in = 2'd0; tick();
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_restart: got %b want 0", seq_err); end
    cnt_in = 2'd2; err_clr = 1'b1; tick();
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_set_wins: got %b want 1", seq_err); end
    cnt_in = 2'd3; tick();
    err_clr = 1'b0;
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_clr2: got %b want 0", seq_err); end
  endtask

  task automatic test_period_done();
    logic e;
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cnt_in = 2'(i % 4); tick();
      e = ((i % 4) == 3);
      if (period_done === 1'b1) pulses++;
      n_vec++; if (period_done !== e) begin n_err++; $display("FAIL pd_cycle i=%0d: got %b want %b", i, period_done, e); end
    end
    n_vec++; if (pulses != 3) begin n_err++; $display("FAIL pd_count: got %0d want 3", pulses); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL pd_seq_err: got %b want 0", seq_err); end
  endtask

  // Reset mid-period with a pending update and a raised error
  task automatic test_reset_mid();
    cnt_in = 2'd0; tick();
    cnt_in = 2'd1; duty_in = 3'd1; duty_valid = 1'b1; tick();
    duty_valid = 1'b0;
    cnt_in = 2'd3; tick();
    cnt_in = 2'd1; tick();
    n_vec++; if (pwm_out !== 1'b1) begin n_err++; $display("FAIL rm_pre_pwm: got %b want 1", pwm_out); end
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL rm_pre_err: got %b want 1", seq_err); end
    n_vec++; if (duty_ready !== 1'b0) begin n_err++; $display("FAIL rm_pre_ready: got %b want 0", duty_ready); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL rm_pwm: got %b want 0", pwm_out); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL rm_err: got %b want 0", seq_err); end
    n_vec++; if (period_done !== 1'b0) begin n_err++; $display("FAIL rm_pd: got %b want 0", period_done); end
    n_vec++; if (duty_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", duty_ready); end
    duty_in = 3'd2; duty_valid = 1'b1;
    tick();
    n_vec++; if (duty_ready !== 1'b1) begin n_err++; $display("FAIL rm_ignore_hs: got %b want 1", duty_ready); end
    rst = 1'b0; duty_valid = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        cnt_in = 2'(c); tick();
        n_vec++; if (pwm_out !== 1'b0) begin n_err++; $display("FAIL rm_post_pwm p=%0d c=%0d: got %b want 0", p, c, pwm_out); end
        n_vec++; if (duty_ready !== 1'b1) begin n_err++; $display("FAIL rm_post_ready p=%0d c=%0d: got %b want 1", p, c, duty_ready); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty2();
    test_saturate();
    test_same_edge();
    test_seq_err();
    test_period_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
